// File: rtl/writeback_stage.sv
// EX-to-WB pipeline register with writeback source select, HEX output register,
// WB-to-EX forwarding selects and a saturating retired-instruction counter.
module writeback_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_EX,
  input  logic        regwrite_EX,
  input  logic [1:0]  regsel_EX,
  input  logic        GPIO_we,
  input  logic [4:0]  rd_EX,
  input  logic [4:0]  rs1_EX,
  input  logic [4:0]  rs2_EX,
  input  logic [31:0] alu_result_EX,
  input  logic [19:0] imm_U_EX,
  input  logic [31:0] readdata1_EX,
  input  logic [31:0] gpio_in,
  output logic        regwrite_WB,
  output logic [4:0]  writeaddr_WB,
  output logic [31:0] writedata_WB,
  output logic [31:0] gpio_out,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic [31:0] retired
);

  logic [31:0] wb_data;
  logic        wb_we;

  always_comb begin
    wb_data = 32'h0;
    case (regsel_EX)
      2'b00:   wb_data = gpio_in;
      2'b01:   wb_data = {imm_U_EX, 12'h000};
      2'b10:   wb_data = alu_result_EX;
      default: wb_data = 32'h0;
    endcase
  end

  assign wb_we = valid_EX & regwrite_EX & (rd_EX != 5'd0) & (regsel_EX != 2'b11);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwrite_WB  <= 1'b0;
      writeaddr_WB <= 5'd0;
      writedata_WB <= 32'h0;
      gpio_out     <= 32'h0;
      retired      <= 32'h0;
    end else begin
      regwrite_WB  <= wb_we;
      writeaddr_WB <= rd_EX;
      writedata_WB <= wb_data;
      if (valid_EX && GPIO_we)
        gpio_out <= readdata1_EX;
      // saturate instead of wrapping to zero
      if (valid_EX && (retired != 32'hFFFF_FFFF))
        retired <= retired + 32'd1;
    end
  end

  assign fwd_a = regwrite_WB & (writeaddr_WB == rs1_EX) & (rs1_EX != 5'd0);
  assign fwd_b = regwrite_WB & (writeaddr_WB == rs2_EX) & (rs2_EX != 5'd0);

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized checks of writeback_stage against a behavioural model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_EX, regwrite_EX, GPIO_we;
  logic [1:0]  regsel_EX;
  logic [4:0]  rd_EX, rs1_EX, rs2_EX;
  logic [31:0] alu_result_EX, readdata1_EX, gpio_in;
  logic [19:0] imm_U_EX;
  logic        regwrite_WB, fwd_a, fwd_b;
  logic [4:0]  writeaddr_WB;
  logic [31:0] writedata_WB, gpio_out, retired;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic        m_rw;
  logic [4:0]  m_wa;
  logic [31:0] m_wd, m_gout;
  longint unsigned m_ret;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_EX(valid_EX), .regwrite_EX(regwrite_EX),
    .regsel_EX(regsel_EX), .GPIO_we(GPIO_we), .rd_EX(rd_EX), .rs1_EX(rs1_EX),
    .rs2_EX(rs2_EX), .alu_result_EX(alu_result_EX), .imm_U_EX(imm_U_EX),
    .readdata1_EX(readdata1_EX), .gpio_in(gpio_in), .regwrite_WB(regwrite_WB),
    .writeaddr_WB(writeaddr_WB), .writedata_WB(writedata_WB), .gpio_out(gpio_out),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_fwd();
    check("fwd_a", {31'd0, fwd_a}, {31'd0, m_rw && m_wa == rs1_EX && rs1_EX != 0});
    check("fwd_b", {31'd0, fwd_b}, {31'd0, m_rw && m_wa == rs2_EX && rs2_EX != 0});
  endtask

  task automatic check_all(input string tag);
    check({tag, ".regwrite_WB"}, {31'd0, regwrite_WB}, {31'd0, m_rw});
    check({tag, ".writeaddr_WB"}, {27'd0, writeaddr_WB}, {27'd0, m_wa});
    check({tag, ".writedata_WB"}, writedata_WB, m_wd);
    check({tag, ".gpio_out"}, gpio_out, m_gout);
    check({tag, ".retired"}, retired, m_ret[31:0]);
    check_fwd();
  endtask

  task automatic instr(input logic v, input logic rw, input logic [1:0] sel,
                       input logic gwe, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [31:0] alu,
                       input logic [19:0] imm, input logic [31:0] rd1,
                       input logic [31:0] gin);
    valid_EX = v; regwrite_EX = rw; regsel_EX = sel; GPIO_we = gwe;
    rd_EX = rd; rs1_EX = r1; rs2_EX = r2; alu_result_EX = alu;
    imm_U_EX = imm; readdata1_EX = rd1; gpio_in = gin;
  endtask

  // one clock: update model from the inputs the DUT samples, then check
  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst_n) begin
      m_rw = 0; m_wa = 0; m_wd = 0; m_gout = 0; m_ret = 0;
    end else begin
      m_wa = rd_EX;
      m_rw = valid_EX && regwrite_EX && rd_EX != 0 && regsel_EX != 2'b11;
      m_wd = (regsel_EX == 2'b00) ? gpio_in :
             (regsel_EX == 2'b01) ? {imm_U_EX, 12'h000} :
             (regsel_EX == 2'b10) ? alu_result_EX : 32'h0;
      if (valid_EX && GPIO_we) m_gout = readdata1_EX;
      if (valid_EX) m_ret = (m_ret + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_ret + 1;
    end
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    m_rw = 0; m_wa = 0; m_wd = 0; m_gout = 0; m_ret = 0;
    rst_n = 1'b0;
    instr(1, 1, 2'b10, 1, 5'd7, 0, 0, 32'h55, 20'h1, 32'hAA, 32'h3);
    @(negedge clk);
    tick("reset");
    tick("reset2");
    rst_n = 1'b1;

    // ADD x5 = 7
    instr(1, 1, 2'b10, 0, 5'd5, 5'd1, 5'd2, 32'h7, 20'h0, 32'h0, 32'h0);
    tick("add_x5");
    check("add_x5.data_const", writedata_WB, 32'h7);
    check("add_x5.retired_const", retired, 32'h1);

    // LUI x3, then consume x3 as rs1
    instr(1, 1, 2'b01, 0, 5'd3, 5'd0, 5'd0, 32'h0, 20'hABCDE, 32'h0, 32'h0);
    tick("lui_x3");
    check("lui_x3.data_const", writedata_WB, 32'hABCDE000);
    instr(1, 1, 2'b10, 0, 5'd8, 5'd3, 5'd4, 32'h9, 20'h0, 32'h0, 32'h0);
    #1;
    check("lui_fwd_a_const", {31'd0, fwd_a}, 32'd1);
    check("lui_fwd_b_const", {31'd0, fwd_b}, 32'd0);
    tick("after_lui");

    // CSRRW io0 to x0, then to x9
    instr(1, 1, 2'b00, 0, 5'd0, 5'd0, 5'd0, 32'h0, 20'h0, 32'h0, 32'h1234);
    tick("csrrw_x0");
    check("csrrw_x0.rw_const", {31'd0, regwrite_WB}, 32'd0);
    instr(1, 1, 2'b00, 0, 5'd9, 5'd0, 5'd0, 32'h0, 20'h0, 32'h0, 32'h1234);
    tick("csrrw_x9");
    check("csrrw_x9.data_const", writedata_WB, 32'h1234);

    // CSRRW io2 -> HEX register, held through 5 non-GPIO instructions
    instr(1, 1, 2'b00, 1, 5'd6, 5'd0, 5'd0, 32'h0, 20'h0, 32'hDEADBEEF, 32'h42);
    tick("csrrw_io2");
    for (int i = 0; i < 5; i++) begin
      instr(1, 1, 2'b10, 0, 5'd10 + 5'(i), 5'd6, 5'(i), 32'(i), 20'h0, 32'h1111 * i, 32'h0);
      tick("hold_gpio");
      check("hold_gpio_const", gpio_out, 32'hDEADBEEF);
    end

    // back-to-back writes to the same rd
    for (int i = 0; i < 3; i++) begin
      instr(1, 1, 2'b10, 0, 5'd12, 5'd12, 5'd0, 32'h100 + 32'(i), 20'h0, 32'h0, 32'h0);
      tick("b2b_same_rd");
    end

    // bubble with regwrite set
    instr(0, 1, 2'b10, 1, 5'd4, 5'd4, 5'd4, 32'h99, 20'h0, 32'h77, 32'h0);
    tick("bubble");

    // reset mid-stream with GPIO_we set
    rst_n = 1'b0;
    instr(1, 1, 2'b10, 1, 5'd4, 5'd4, 5'd4, 32'h99, 20'h0, 32'h77, 32'h0);
    tick("mid_reset");
    check("mid_reset.gpio_const", gpio_out, 32'h0);
    check("mid_reset.retired_const", retired, 32'h0);
    rst_n = 1'b1;

    // randomized instructions
    for (int i = 0; i < 300; i++) begin
      instr($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), $urandom_range(0, 5) == 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom, 20'($urandom), $urandom, $urandom);
      rst_n = ($urandom_range(0, 49) != 0);
      tick("rand");
    end
    rst_n = 1'b1;

    // saturation of the retired counter
    force dut.retired = 32'hFFFF_FFFE;
    #1;
    release dut.retired;
    m_ret = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      instr(1, 1, 2'b10, 0, 5'd1, 5'd0, 5'd0, 32'h5, 20'h0, 32'h0, 32'h0);
      tick("saturate");
      check("saturate_const", retired, 32'hFFFF_FFFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-low.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- valid_EX  in  1  instruction in EX is real; 0 means bubble.
- regwrite_EX  in  1  EX instruction writes rd.
- regsel_EX  in  2  writeback source: 00 switches, 01 U-immediate, 10 ALU result, 11 reserved.
- GPIO_we  in  1  EX instruction writes the HEX register.
- rd_EX  in  5  destination register of EX instruction.
- rs1_EX, rs2_EX  in  5 each  source registers of EX instruction.
- alu_result_EX  in  32  ALU output in EX.
- imm_U_EX  in  20  U-type immediate (instr[31:12]).
- readdata1_EX  in  32  register-file rs1 data in EX (CSRRW source).
- gpio_in  in  32  switch inputs, asynchronous to nothing, sampled on clk.
- regwrite_WB  out  1  register-file write enable.
- writeaddr_WB  out  5  register-file write address.
- writedata_WB  out  32  register-file write data.
- gpio_out  out  32  HEX display register.
- fwd_a, fwd_b  out  1 each  select forwarded writedata_WB for rs1/rs2 in EX.
- retired  out  32  count of instructions retired.

Function
REQ-003 On each rising clk edge with rst_n=1, the block SHALL register EX into WB: writeaddr_WB<=rd_EX, regwrite_WB<=valid_EX & regwrite_EX & (rd_EX!=0) & (regsel_EX!=11).
REQ-004 writedata_WB SHALL be registered from: 00 -> gpio_in; 01 -> {imm_U_EX,12'h000}; 10 -> alu_result_EX; 11 -> 32'h0.
REQ-005 gpio_in SHALL be sampled at the same edge as the EX-to-WB transfer (one-cycle latency from EX to writedata_WB).
REQ-006 When valid_EX=0, regwrite_WB SHALL be 0 next cycle; writeaddr_WB/writedata_WB SHALL still update (don't-care).
REQ-007 Writes to x0 SHALL never assert regwrite_WB.
REQ-008 When valid_EX=1 and GPIO_we=1, gpio_out SHALL load readdata1_EX at that edge; otherwise it SHALL hold.
REQ-009 GPIO_we with regwrite_EX both set (CSRRW to io2 with rd!=0) SHALL perform both actions; regsel_EX selects the rd value.
REQ-010 fwd_a SHALL be combinational: regwrite_WB & (writeaddr_WB==rs1_EX) & (rs1_EX!=0); fwd_b likewise with rs2_EX.
REQ-011 gpio_out SHALL not be forwarded; fwd_a/fwd_b SHALL depend only on WB register state and rs1_EX/rs2_EX.
REQ-012 retired SHALL increment by 1 at each edge where valid_EX=1, saturating at 32'hFFFF_FFFF (no wrap).
REQ-013 Back-to-back writes to the same rd SHALL each appear for exactly one cycle, in order.

Reset
REQ-014 With rst_n=0 at a rising edge, the block SHALL set regwrite_WB=0, writeaddr_WB=0, writedata_WB=0, gpio_out=0, retired=0.
REQ-015 Reset SHALL take priority over any simultaneous valid_EX, GPIO_we, or counter increment; outputs SHALL change only at clock edges.
REQ-016 fwd_a=fwd_b=0 SHALL hold while regwrite_WB=0, including the cycle after reset.

Verification
REQ-017 ADD to x5, alu_result_EX=0x0000_0007, regsel 10, valid -> next cycle regwrite_WB=1, writeaddr_WB=5, writedata_WB=7, retired=1.
REQ-018 LUI x3, imm_U_EX=0xABCDE, regsel 01 -> writedata_WB=0xABCDE000; then rs1_EX=3 -> fwd_a=1, fwd_b=0.
REQ-019 CSRRW io0 to x0, gpio_in=0x1234 -> regwrite_WB=0; same with rd=9 -> writedata_WB=0x1234, writeaddr_WB=9.
REQ-020 CSRRW io2, readdata1_EX=0xDEADBEEF, GPIO_we=1 -> gpio_out=0xDEADBEEF next cycle, held through 5 non-GPIO instructions.
REQ-021 valid_EX=0 with regwrite_EX=1 -> regwrite_WB=0, retired unchanged; rst_n=0 mid-stream with GPIO_we=1 -> gpio_out=0, retired=0.
REQ-022 Preload retired to 0xFFFF_FFFE via 2 fewer increments in force or long run, then 3 valid cycles -> retired=0xFFFF_FFFF, no wrap.
